// File: rtl/ks_clmul_pp_gen_pkg.sv
// Shared constants, FSM states and a reference carry-less multiply for the
// Karatsuba partial-product generator.
package ks_clmul_pp_gen_pkg;

    localparam int KS_HW = 16;
    localparam int KS_PW = 2 * KS_HW - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [KS_PW-1:0] clmul(input logic [KS_HW-1:0] x,
                                               input logic [KS_HW-1:0] y);
        logic [KS_PW-1:0] r;
        r = '0;
        for (int i = 0; i < KS_HW; i++) begin
            if (y[i]) r = r ^ (KS_PW'(x) << i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ks_clmul_pp_gen_step.sv
// One shift-and-XOR step: folds BPC multiplier bits, starting at bit j_i,
// into a partial-product accumulator.
module clmul_acc_step #(
    parameter  int HW  = 16,
    parameter  int BPC = 1,
    localparam int PW  = 2 * HW - 1,
    localparam int JW  = $clog2(HW)
) (
    input  logic [PW-1:0]  acc_i,
    input  logic [HW-1:0]  mcand_i,
    input  logic [BPC-1:0] mbits_i,
    input  logic [JW-1:0]  j_i,
    output logic [PW-1:0]  acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int k = 0; k < BPC; k++) begin
            // j_i + k never exceeds HW-1, so the shifted term fits in PW bits.
            if (mbits_i[k]) acc_o = acc_o ^ (PW'(mcand_i) << (int'(j_i) + k));
        end
    end

endmodule

// File: rtl/ks_clmul_pp_gen.sv
// Sequential producer of Karatsuba partial products z0/z1/z2 for a 2*HW-bit
// carry-less multiply; one shared step datapath per product.
module ks_clmul_pp_gen
    import ks_clmul_pp_gen_pkg::*;
#(
    parameter  int HW  = KS_HW,
    parameter  int BPC = 1,
    localparam int PW  = 2 * HW - 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*HW-1:0] a,
    input  logic [2*HW-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PW-1:0]   z0,
    output logic [PW-1:0]   z1,
    output logic [PW-1:0]   z2
);

    localparam int NSTEP = HW / BPC;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int JW    = $clog2(HW);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    // Index 0 = low halves (z0), 1 = lo^hi (z1), 2 = high halves (z2).
    logic [2:0][HW-1:0]     mcand_q, mcand_d, mult_q, mult_d;
    logic [2:0][PW-1:0]     acc_q, acc_d, acc_step;
    logic [2:0][BPC-1:0]    mbits;
    logic [JW-1:0]          j_base;

    assign j_base = JW'(int'(cnt_q) * BPC);

    for (genvar g = 0; g < 3; g++) begin : g_step
        assign mbits[g] = mult_q[g][j_base +: BPC];

        clmul_acc_step #(.HW(HW), .BPC(BPC)) u_step (
            .acc_i   (acc_q[g]),
            .mcand_i (mcand_q[g]),
            .mbits_i (mbits[g]),
            .j_i     (j_base),
            .acc_o   (acc_step[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d[0] = a[HW-1:0];
                    mcand_d[1] = a[HW-1:0] ^ a[2*HW-1:HW];
                    mcand_d[2] = a[2*HW-1:HW];
                    mult_d[0]  = b[HW-1:0];
                    mult_d[1]  = b[HW-1:0] ^ b[2*HW-1:HW];
                    mult_d[2]  = b[2*HW-1:HW];
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NSTEP - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign z0        = acc_q[0];
    assign z1        = acc_q[1];
    assign z2        = acc_q[2];

    // Finished accumulators must equal the reference product of the latched operands.
    if (HW == KS_HW) begin : g_chk
        always_ff @(posedge clk) begin
            if (rst_n && state_q == DONE) begin
                assert (acc_q[0] == clmul(mcand_q[0], mult_q[0]));
                assert (acc_q[1] == clmul(mcand_q[1], mult_q[1]));
                assert (acc_q[2] == clmul(mcand_q[2], mult_q[2]));
            end
        end
    end

endmodule

// File: tb/tb_ks_clmul_pp_gen.sv
// Directed bench for ks_clmul_pp_gen: hand-computed partial products plus an
// end-to-end check through the Karatsuba recombination network.
module tb_ks_clmul_pp_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [30:0] z0, z1, z2;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    ks_clmul_pp_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z0        (z0),
        .z1        (z1),
        .z2        (z2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref64(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (y[i]) r = r ^ ({32'b0, x} << i);
        end
        return r;
    endfunction

    // Output-stage recombination of the three partial products.
    task automatic e2e(input string tag, input logic [31:0] ta, input logic [31:0] tb_);
        logic [63:0] full;
        full = ({33'b0, z2} << 32) ^ ({33'b0, z0 ^ z1 ^ z2} << 16) ^ {33'b0, z0};
        chk(tag, full, ref64(ta, tb_));
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick;
            cycles++;
        end
    endtask

    // Accept one operation, scramble a/b afterwards, check latency and products.
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic [30:0] e0, input logic [30:0] e1, input logic [30:0] e2);
        int l;
        a        = ta;
        b        = tb_;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        chk({tag, "_in_ready_busy"}, {63'b0, in_ready}, 64'd0);
        wait_done(l);
        chk({tag, "_latency"}, 64'(l), 64'd16);
        chk({tag, "_z0"}, {33'b0, z0}, {33'b0, e0});
        chk({tag, "_z1"}, {33'b0, z1}, {33'b0, e1});
        chk({tag, "_z2"}, {33'b0, z2}, {33'b0, e2});
        e2e({tag, "_e2e"}, ta, tb_);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, "_rel_out_valid"}, {63'b0, out_valid}, 64'd0);
        chk({tag, "_rel_in_ready"}, {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick;
        tick;
        rst_n = 1'b1;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_z0", {33'b0, z0}, 64'd0);
        chk("rst_z1", {33'b0, z1}, 64'd0);
        chk("rst_z2", {33'b0, z2}, 64'd0);

        // Idle with stray out_ready: nothing may move.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("idle_out_valid", {63'b0, out_valid}, 64'd0);
            chk("idle_in_ready", {63'b0, in_ready}, 64'd1);
        end
        out_ready = 1'b0;
        chk("idle_z", {33'b0, z0 | z1 | z2}, 64'd0);

        do_op("unit", 32'h0001_0001, 32'h0001_0001, 31'h1, 31'h0, 31'h1);
        release_out("unit");

        do_op("mix", 32'hFFFF_0003, 32'h0001_0003, 31'h5, 31'h1FFF8, 31'hFFFF);
        // Held results with a competing request that must be ignored.
        in_valid = 1'b1;
        a        = 32'h1234_5678;
        b        = 32'h9ABC_DEF0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
            chk("hold_out_valid", {63'b0, out_valid}, 64'd1);
            chk("hold_z0", {33'b0, z0}, 64'h5);
            chk("hold_z1", {33'b0, z1}, 64'h1FFF8);
            chk("hold_z2", {33'b0, z2}, 64'hFFFF);
        end
        in_valid = 1'b0;
        release_out("mix");

        do_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 31'h5555_5555, 31'h0, 31'h5555_5555);
        release_out("ones");

        do_op("zero", 32'h0, 32'h0, 31'h0, 31'h0, 31'h0);
        release_out("zero");

        // Back-to-back: in_valid held, out_ready high throughout.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 32'h0002_0001;
        b         = 32'h0003_0005;
        tick;
        a = 32'h8000_8000;
        b = 32'h8000_0001;
        lat = 0;
        while (!in_ready && lat < 40) begin
            if (out_valid) begin
                chk("b2b1_z0", {33'b0, z0}, 64'h5);
                chk("b2b1_z1", {33'b0, z1}, 64'hA);
                chk("b2b1_z2", {33'b0, z2}, 64'h6);
                e2e("b2b1_e2e", 32'h0002_0001, 32'h0003_0005);
            end
            tick;
            lat++;
        end
        chk("b2b_gap", 64'(lat + 1), 64'd18);
        tick;
        in_valid = 1'b0;
        wait_done(lat);
        chk("b2b2_latency", 64'(lat), 64'd16);
        chk("b2b2_z0", {33'b0, z0}, 64'h8000);
        chk("b2b2_z1", {33'b0, z1}, 64'h0);
        chk("b2b2_z2", {33'b0, z2}, 64'h4000_0000);
        e2e("b2b2_e2e", 32'h8000_8000, 32'h8000_0001);
        tick;
        out_ready = 1'b0;
        chk("b2b_one_cycle_done", {63'b0, out_valid}, 64'd0);

        // Abort in the middle of RUN.
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
        chk("abort_out_valid", {63'b0, out_valid}, 64'd0);
        chk("abort_z", {33'b0, z0 | z1 | z2}, 64'd0);
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("abort_no_valid", {63'b0, out_valid}, 64'd0);
        end

        do_op("post", 32'h00F0_0F00, 32'h0011_0101, 31'h0F_0F00, 31'hF_0F00, 31'hFF0);
        release_out("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ks_clmul_pp_gen.md
Name: ks_clmul_pp_gen

Overview:
- Sequential producer of the three Karatsuba partial products (z0, z1, z2) consumed by the 31-bit output-stage XOR recombination network.
- Accepts two 32-bit GF(2) polynomial operands, each split into 16-bit halves.
- Computes three 16x16 carry-less products with a shared shift-and-XOR datapath, HW/BPC cycles per operation.
- Presents z0/z1/z2 on a valid/ready interface, sized to drive the output stage directly.

Parameters:
- HW, 16, half-operand width in bits.
- PW, 2*HW-1 (31), partial-product width; derived, not overridable.
- BPC, 1, multiplier bits consumed per cycle; HW must be divisible by BPC.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  2*HW  operand A; a_lo = a[HW-1:0], a_hi = a[2HW-1:HW].
- b  in  2*HW  operand B; same split as a.
- out_valid  out  1  z0/z1/z2 valid.
- out_ready  in  1  consumer accepts results.
- z0  out  PW  clmul(a_lo, b_lo).
- z1  out  PW  clmul(a_lo^a_hi, b_lo^b_hi).
- z2  out  PW  clmul(a_hi, b_hi).

Behaviour:
- Reset is synchronous and active-low on clk; one clock domain only.
- Reset values (rst_n low at an edge):
  - state = IDLE, cnt = 0.
  - z0 = z1 = z2 = 0, out_valid = 0, in_ready = 1 after that edge.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
    - Handshake in_valid & in_ready at an edge: register a_lo, a_hi, a_lo^a_hi as multiplicands and b_lo, b_hi, b_lo^b_hi as multipliers.
    - Same edge: clear all three accumulators, cnt = 0, go to RUN.
  - RUN: in_ready = 0, out_valid = 0.
    - Each edge, for each k in 0..BPC-1 with j = cnt*BPC + k: if multiplier bit j = 1, acc ^= multiplicand << j. Apply independently per product.
    - cnt increments each edge. At the edge where cnt = HW/BPC-1, go to DONE.
  - DONE: out_valid = 1; z0/z1/z2 = accumulators, held stable.
    - Handshake out_valid & out_ready at an edge: go to IDLE.
- Latency:
  - Operands accepted at edge k; out_valid = 1 after edge k+HW/BPC (16 for defaults).
  - Throughput: one operation per HW/BPC+2 cycles. No overlap; in_ready = 0 in RUN and DONE.
- Arithmetic:
  - Pure XOR, no carries.
  - Shifted multiplicand is at most PW bits (bit 2HW-2 is the max); no truncation occurs.
  - Accumulators are exactly PW bits.
- Boundaries:
  - in_valid while not IDLE: ignored. Operands are sampled only at the accept edge; later changes on a/b have no effect.
  - out_ready held high: DONE lasts exactly one cycle.
  - out_ready low: results held indefinitely, no loss.
  - rst_n low in RUN or DONE: abort; outputs return to reset values at that edge, and no out_valid is produced for the aborted operation.
  - Zero operands give all-zero products after full latency; there is no early termination.
  - out_ready while out_valid = 0: ignored.

Decomposition:
- Shared package:
  - HW and PW constants.
  - State enum {IDLE, RUN, DONE}.
  - Reference function clmul(x, y) used by the bench and by assertions.
- One natural sub-module: clmul_acc_step.
  - Combinational: acc_next = acc ^ XOR over k of (mbit[k] ? mcand << (j+k) : 0).
  - Instantiated three times, once each for z0, z1, z2.
- FSM, counter and handshake logic stay in the top module.

Test Plan:
- Reset then idle: after reset in_ready=1, out_valid=0, z0=z1=z2=0. Hold in_valid=0 for 20 cycles -> no change.
- a=0x0001_0001, b=0x0001_0001 -> after 16 cycles out_valid=1, z0=0x1, z2=0x1, z1=0x0.
- a=0xFFFF_0003, b=0x0001_0003 -> z0=0x5, z2=0xFFFF, z1=0x1FFF8. Hold out_ready=0 for 10 cycles -> values stable and in_ready=0 throughout.
- a=0xFFFF_FFFF, b=0xFFFF_FFFF -> z0=z2=0x55555555, z1=0 (a_lo^a_hi=0).
- Back-to-back with out_ready=1: second in_valid is held from the first accept. Expect the second accept exactly HW/BPC+2 cycles after the first and both results correct.
- Reset mid-operation:
  - Assert rst_n=0 at RUN cycle 7 -> IDLE next edge, outputs zero.
  - New operation afterwards completes correctly.
- End-to-end check: feed z0/z1/z2 into the output-stage recombination network and compare against the bench model.
